hera_boot_loader: RTL and testbench

Serial program loader for the HERA core. It receives a framed program image over an 8N1 UART line and writes it word-by-word into the instruction memory that the core fetches from. It holds the core in reset until a complete image with a valid checksum has been written. It sits beside `hera_rom`'s write port and drives the core's reset, so it is the writer for the core's instruction-fetch reader.

---
 rtl/hera_boot_pkg.sv | 32 +++
 rtl/hera_uart_rx.sv | 132 +++++++++++++
 rtl/hera_boot_loader.sv | 173 +++++++++++++++++
 tb/tb_hera_boot_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hera_boot_pkg.sv
// Shared definitions for the HERA serial program loader.
package hera_boot_pkg;

    localparam logic [7:0] SYNC_BYTE        = 8'hA5;
    localparam int         DEF_CLKS_PER_BIT = 434;

    // Loader frame-parsing states.
    typedef enum logic [2:0] {
        ST_WAIT_SYNC = 3'd0,
        ST_LEN_HI    = 3'd1,
        ST_LEN_LO    = 3'd2,
        ST_DATA_HI   = 3'd3,
        ST_DATA_LO   = 3'd4,
        ST_CSUM      = 3'd5,
        ST_DONE      = 3'd6,
        ST_ERR       = 3'd7
    } boot_state_e;

    // UART receiver bit-phase states.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Running frame checksum: 8-bit sum, wraps mod 256.
    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

endpackage

// File: rtl/hera_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, glitch-filtered start.
module hera_uart_rx
    import hera_boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int              CNT_W   = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       sync_q;
    logic             prev_q;
    logic             rx_s;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    assign rx_s     = sync_q[1];
    assign rx_byte  = byte_q;
    assign rx_valid = valid_q;
    assign rx_ferr  = ferr_q;

    // Synchronize the asynchronous line and keep one cycle of history for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rxd};
            prev_q <= sync_q[1];
        end
    end

    // Receiver state, bit timer, shift register and registered byte strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            byte_q  <= 8'd0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Bit-phase sequencing: start re-check at half bit, then one sample per bit period.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx_s) begin
                    state_d = RX_START;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    if (rx_s) begin
                        state_d = RX_IDLE;      // too short to be a start bit
                    end else begin
                        state_d = RX_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_s) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/hera_boot_loader.sv
// HERA program loader: parses a framed UART image, writes instruction memory,
// and releases the core reset once the checksum verifies.
module hera_boot_loader
    import hera_boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [15:0]       prog_data,
    output logic              prog_we,
    output logic              core_rst_n,
    output logic              done,
    output logic              err
);

    localparam logic [16:0]       MAX_LEN  = 17'd1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [7:0]        rx_byte_s;
    logic              rx_valid_s;
    logic              rx_ferr_s;
    logic [16:0]       len_full_s;

    boot_state_e       state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic [7:0]        sum_q, sum_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
    logic [15:0]       prog_data_q, prog_data_d;
    logic              prog_we_q, prog_we_d;
    logic              done_q, err_q, core_rst_n_q;

    hera_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .rx_byte  (rx_byte_s),
        .rx_valid (rx_valid_s),
        .rx_ferr  (rx_ferr_s)
    );

    // Full length as it will be once the low byte is latched; one extra bit for the 2^ADDR_W case.
    assign len_full_s = {1'b0, len_q[15:8], rx_byte_s};

    assign prog_addr  = prog_addr_q;
    assign prog_data  = prog_data_q;
    assign prog_we    = prog_we_q;
    assign core_rst_n = core_rst_n_q;
    assign done       = done_q;
    assign err        = err_q;

    // Loader state, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_WAIT_SYNC;
            len_q        <= 16'd0;
            wcnt_q       <= 16'd0;
            sum_q        <= 8'd0;
            addr_q       <= '0;
            hi_q         <= 8'd0;
            prog_addr_q  <= '0;
            prog_data_q  <= 16'd0;
            prog_we_q    <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            wcnt_q       <= wcnt_d;
            sum_q        <= sum_d;
            addr_q       <= addr_d;
            hi_q         <= hi_d;
            prog_addr_q  <= prog_addr_d;
            prog_data_q  <= prog_data_d;
            prog_we_q    <= prog_we_d;
            done_q       <= (state_d == ST_DONE);
            err_q        <= (state_d == ST_ERR);
            core_rst_n_q <= (state_d == ST_DONE);
        end
    end

    // Frame parser: one byte per rx_valid; framing errors abort an in-progress frame.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wcnt_d      = wcnt_q;
        sum_d       = sum_q;
        addr_d      = addr_q;
        hi_d        = hi_q;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;
        prog_we_d   = 1'b0;
        if (rx_ferr_s) begin
            if ((state_q != ST_WAIT_SYNC) && (state_q != ST_DONE)) begin
                state_d = ST_ERR;
            end else begin
                state_d = state_q;
            end
        end else if (rx_valid_s) begin
            case (state_q)
                ST_WAIT_SYNC, ST_ERR: begin
                    if (rx_byte_s == SYNC_BYTE) begin
                        state_d = ST_LEN_HI;
                        sum_d   = 8'd0;
                        addr_d  = '0;
                        wcnt_d  = 16'd0;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_LEN_HI: begin
                    len_d   = {rx_byte_s, len_q[7:0]};
                    sum_d   = csum_add(sum_q, rx_byte_s);
                    state_d = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    len_d = len_full_s[15:0];
                    sum_d = csum_add(sum_q, rx_byte_s);
                    if (len_full_s > MAX_LEN) begin
                        state_d = ST_ERR;
                    end else if (len_full_s == 17'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
                ST_DATA_HI: begin
                    hi_d    = rx_byte_s;
                    sum_d   = csum_add(sum_q, rx_byte_s);
                    state_d = ST_DATA_LO;
                end
                ST_DATA_LO: begin
                    prog_we_d   = 1'b1;
                    prog_addr_d = addr_q;
                    prog_data_d = {hi_q, rx_byte_s};
                    addr_d      = addr_q + ADDR_ONE;   // wraps after the top word; no write follows
                    wcnt_d      = wcnt_q + 16'd1;
                    sum_d       = csum_add(sum_q, rx_byte_s);
                    if ((wcnt_q + 16'd1) == len_q) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
                ST_CSUM: begin
                    if (rx_byte_s == sum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_WAIT_SYNC;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

endmodule

// File: tb/tb_hera_boot_loader.sv
// Scoreboard bench for hera_boot_loader: frames are serialized onto rxd, the
// expected memory writes are queued as words are sent and popped on prog_we.
module tb_hera_boot_loader;

    localparam int CPB = 4;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tx_line = 1'b1;
    logic        sel_b = 1'b0;
    logic        rxd_a, rxd_b;

    logic [9:0]  addr_a;
    logic [15:0] data_a;
    logic        we_a, crn_a, done_a, err_a;
    logic [3:0]  addr_b;
    logic [15:0] data_b;
    logic        we_b, crn_b, done_b, err_b;

    int          n_vec  = 0;
    int          n_miss = 0;
    wr_t         exp_a[$];
    wr_t         exp_b[$];
    wr_t         ea, eb;
    logic [15:0] words[$];
    logic [15:0] last_addr_b = 16'hFFFF;

    assign rxd_a = sel_b ? 1'b1 : tx_line;
    assign rxd_b = sel_b ? tx_line : 1'b1;

    always #5 clk = ~clk;

    hera_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(10)) dut_a (
        .clk(clk), .rst(rst), .rxd(rxd_a),
        .prog_addr(addr_a), .prog_data(data_a), .prog_we(we_a),
        .core_rst_n(crn_a), .done(done_a), .err(err_a)
    );

    // Small-address instance so a full 2^ADDR_W image stays short.
    hera_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(4)) dut_b (
        .clk(clk), .rst(rst), .rxd(rxd_b),
        .prog_addr(addr_b), .prog_data(data_b), .prog_we(we_b),
        .core_rst_n(crn_b), .done(done_b), .err(err_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor for instance A: every prog_we cycle consumes one expected write.
    always @(negedge clk) begin
        if (rst && we_a === 1'b1) begin
            if (exp_a.size() == 0) begin
                check_eq("wr_a_unexpected", 32'(exp_a.size()), 32'd1);
            end else begin
                ea = exp_a.pop_front();
                check_eq("wr_a_addr", 32'(addr_a), 32'(ea.addr));
                check_eq("wr_a_data", 32'(data_a), 32'(ea.data));
            end
        end
    end

    // Write monitor for instance B.
    always @(negedge clk) begin
        if (rst && we_b === 1'b1) begin
            last_addr_b = 16'(addr_b);
            if (exp_b.size() == 0) begin
                check_eq("wr_b_unexpected", 32'(exp_b.size()), 32'd1);
            end else begin
                eb = exp_b.pop_front();
                check_eq("wr_b_addr", 32'(addr_b), 32'(eb.addr));
                check_eq("wr_b_data", 32'(data_b), 32'(eb.data));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        @(negedge clk) tx_line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            tx_line = b[i];
            repeat (CPB) @(negedge clk);
        end
        tx_line = stop_v;
        repeat (CPB) @(negedge clk);
        tx_line = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    // Sends sync, length, the words queue and the checksum (plus delta to corrupt it).
    task automatic send_frame(input bit to_b, input logic [15:0] len,
                              input logic [7:0] delta, input bit glitch);
        logic [7:0] sum;
        wr_t        w;
        sum = len[15:8] + len[7:0];
        send_byte(8'hA5, 1'b1);
        if (glitch) begin
            @(negedge clk) tx_line = 1'b0;
            @(negedge clk) tx_line = 1'b1;
            repeat (4 * CPB) @(negedge clk);
        end
        send_byte(len[15:8], 1'b1);
        send_byte(len[7:0], 1'b1);
        for (int i = 0; i < words.size(); i++) begin
            w.addr = to_b ? 16'(i % 16) : 16'(i % 1024);
            w.data = words[i];
            if (to_b) exp_b.push_back(w);
            else      exp_a.push_back(w);
            send_byte(words[i][15:8], 1'b1);
            send_byte(words[i][7:0], 1'b1);
            sum = sum + words[i][15:8] + words[i][7:0];
        end
        send_byte(sum + delta, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_addr", 32'(addr_a), 32'd0);
        check_eq("rst_data", 32'(data_a), 32'd0);
        check_eq("rst_we", 32'(we_a), 32'd0);
        check_eq("rst_crn", 32'(crn_a), 32'd0);
        check_eq("rst_done", 32'(done_a), 32'd0);
        check_eq("rst_err", 32'(err_a), 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Basic load: checksum of 00 02 12 34 AB CD is 0xC0
        words = '{16'h1234, 16'hABCD};
        send_frame(1'b0, 16'd2, 8'd0, 1'b0);
        check_eq("basic_done", 32'(done_a), 32'd1);
        check_eq("basic_crn", 32'(crn_a), 32'd1);
        check_eq("basic_err", 32'(err_a), 32'd0);
        check_eq("basic_pending", 32'(exp_a.size()), 32'd0);

        // Reset after DONE must drop core_rst_n immediately
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("rst_after_done_crn", 32'(crn_a), 32'd0);
        check_eq("rst_after_done_done", 32'(done_a), 32'd0);
        @(negedge clk) rst = 1'b1;

        // Bad checksum, then recovery with a good frame
        send_frame(1'b0, 16'd2, 8'd1, 1'b0);
        check_eq("badcs_err", 32'(err_a), 32'd1);
        check_eq("badcs_crn", 32'(crn_a), 32'd0);
        check_eq("badcs_done", 32'(done_a), 32'd0);
        check_eq("badcs_pending", 32'(exp_a.size()), 32'd0);
        send_frame(1'b0, 16'd2, 8'd0, 1'b0);
        check_eq("recover_err", 32'(err_a), 32'd0);
        check_eq("recover_done", 32'(done_a), 32'd1);
        do_reset();

        // Garbage bytes then a zero-length frame
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        words = {};
        send_frame(1'b0, 16'd0, 8'd0, 1'b0);
        check_eq("zero_done", 32'(done_a), 32'd1);
        check_eq("zero_err", 32'(err_a), 32'd0);
        do_reset();

        // Start glitch between sync and LEN_HI must not create a byte
        words = '{16'h7E01};
        send_frame(1'b0, 16'd1, 8'd0, 1'b1);
        check_eq("glitch_done", 32'(done_a), 32'd1);
        check_eq("glitch_err", 32'(err_a), 32'd0);
        check_eq("glitch_pending", 32'(exp_a.size()), 32'd0);
        do_reset();

        // Framing error while in DATA_HI
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b0);
        check_eq("ferr_err", 32'(err_a), 32'd1);
        check_eq("ferr_crn", 32'(crn_a), 32'd0);
        do_reset();

        // Oversize length on the 10-bit instance
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h01, 1'b1);
        check_eq("oversize_a_err", 32'(err_a), 32'd1);
        do_reset();

        // Full 16-word image and oversize length on the 4-bit instance
        sel_b = 1'b1;
        words = {};
        for (int i = 0; i < 16; i++) words.push_back(16'($urandom));
        send_frame(1'b1, 16'd16, 8'd0, 1'b0);
        check_eq("full_b_done", 32'(done_b), 32'd1);
        check_eq("full_b_crn", 32'(crn_b), 32'd1);
        check_eq("full_b_last_addr", 32'(last_addr_b), 32'h0F);
        check_eq("full_b_pending", 32'(exp_b.size()), 32'd0);
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        check_eq("oversize_b_err", 32'(err_b), 32'd1);
        sel_b = 1'b0;
        do_reset();

        // Reset after the first data word of a frame
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        exp_a.push_back('{addr: 16'd0, data: 16'h1234});
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        check_eq("mid_pre_data", 32'(data_a), 32'h1234);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("mid_addr", 32'(addr_a), 32'd0);
        check_eq("mid_data", 32'(data_a), 32'd0);
        check_eq("mid_we", 32'(we_a), 32'd0);
        check_eq("mid_crn", 32'(crn_a), 32'd0);
        check_eq("mid_done", 32'(done_a), 32'd0);
        check_eq("mid_err", 32'(err_a), 32'd0);
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        words = '{16'h55AA};
        send_frame(1'b0, 16'd1, 8'd0, 1'b0);
        check_eq("fresh_done", 32'(done_a), 32'd1);
        check_eq("fresh_pending", 32'(exp_a.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
